// File: rtl/riscp_pkg.sv
// rtl/riscp_pkg.sv - shared types and default widths for the memory stage
package riscp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01
  } state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_RD_W     = 3;
  localparam int DEF_MAX_WAIT = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait counter flagging a hung memory access
module mem_wait_timer #(
  parameter int MAX_WAIT = riscp_pkg::DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                                  cnt_d = '0;
    else if (enable && cnt_q != CW'(MAX_WAIT)) cnt_d = cnt_q + 1'b1;
  end

  // Fires during the MAX_WAIT-th ACCESS cycle so the request is held exactly MAX_WAIT cycles.
  assign expired = enable && (cnt_q >= CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: ALU pass-through or req/ack data-memory access
module mem_stage
  import riscp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_W     = DEF_RD_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic              mem_err
);

  state_e            state_q, state_d;
  logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [DATA_W-1:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic              regw_q, regw_d;
  logic              wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              mem_err_q, mem_err_d;
  logic              accept, is_mem, in_access, timer_expired;

  assign ex_ready  = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);
  assign accept    = ex_valid && ex_ready;
  assign is_mem    = ex_mem_read || ex_mem_write;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_access || dm_ack || timer_expired),
    .enable  (in_access),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      dm_addr_q      <= '0;
      dm_wdata_q     <= '0;
      rd_q           <= '0;
      regw_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      dm_req_q       <= dm_req_d;
      dm_we_q        <= dm_we_d;
      dm_addr_q      <= dm_addr_d;
      dm_wdata_q     <= dm_wdata_d;
      rd_q           <= rd_d;
      regw_q         <= regw_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      mem_err_q      <= mem_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem) state_d = ACCESS;
      ACCESS:  if (dm_ack || timer_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dm_req_d       = dm_req_q;
    dm_we_d        = dm_we_q;
    dm_addr_d      = dm_addr_q;
    dm_wdata_d     = dm_wdata_q;
    rd_d           = rd_q;
    regw_d         = regw_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    mem_err_d      = mem_err_q;
    if (state_q == IDLE && accept) begin
      if (is_mem) begin
        // mem_write dominates: a read+write instruction is issued as a store.
        dm_req_d   = 1'b1;
        dm_we_d    = ex_mem_write;
        dm_addr_d  = ex_alu_result;
        dm_wdata_d = ex_store_data;
        rd_d       = ex_rd;
        regw_d     = ex_reg_write;
      end else begin
        wb_valid_d     = 1'b1;
        wb_data_d      = ex_alu_result;
        wb_rd_d        = ex_rd;
        wb_reg_write_d = ex_reg_write;
      end
    end else if (in_access) begin
      if (dm_ack) begin
        dm_req_d   = 1'b0;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        if (dm_we_q) begin
          wb_data_d = dm_addr_q;
        end else begin
          wb_data_d      = dm_rdata;
          wb_reg_write_d = regw_q;
        end
      end else if (timer_expired) begin
        dm_req_d   = 1'b0;
        mem_err_d  = 1'b1;
        wb_valid_d = 1'b1;
        wb_data_d  = '0;
      end
    end
  end

  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [15:0] ex_alu_result, ex_store_data;
  logic        ex_mem_read, ex_mem_write;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(16), .RD_W(3), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .mem_err       (mem_err)
  );

  typedef struct {
    logic [15:0] alu;
    logic [2:0]  rd;
    logic        rw;
    logic [15:0] exp_data;
    logic [2:0]  exp_rd;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_reg_write  = 1'b0;
    ex_rd         = 3'd0;
    ex_alu_result = 16'h0;
    ex_store_data = 16'h0;
  endtask

  task automatic issue(input logic [15:0] alu, input logic [15:0] sd, input logic rd_en,
                       input logic wr_en, input logic [2:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    vecs[0] = '{16'h1234, 3'd5, 1'b1, 16'h1234, 3'd5, 1'b1};
    vecs[1] = '{16'hFFFF, 3'd7, 1'b0, 16'hFFFF, 3'd7, 1'b0};
    vecs[2] = '{16'h0000, 3'd0, 1'b1, 16'h0000, 3'd0, 1'b1};
    vecs[3] = '{16'hA5C3, 3'd2, 1'b1, 16'hA5C3, 3'd2, 1'b1};

    idle_inputs();
    dm_ack   = 1'b0;
    dm_rdata = 16'h0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back non-memory ops, one retire per cycle.
    issue(vecs[0].alu, 16'h0, 1'b0, 1'b0, vecs[0].rd, vecs[0].rw);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("alu%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("alu%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].exp_data));
      chk($sformatf("alu%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].exp_rd));
      chk($sformatf("alu%0d_wb_rw", i), 32'(wb_reg_write), 32'(vecs[i].exp_rw));
      chk($sformatf("alu%0d_ex_ready", i), 32'(ex_ready), 32'd1);
      if (i < 3) issue(vecs[i+1].alu, 16'h0, 1'b0, 1'b0, vecs[i+1].rd, vecs[i+1].rw);
      else       idle_inputs();
    end
    @(negedge clk);
    chk("alu_pulse_ends", 32'(wb_valid), 32'd0);

    // dm_ack while idle must be ignored.
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("idle_ack_dm_req", 32'(dm_req), 32'd0);

    // Load 0x0040, ack on third ACCESS cycle with 0xBEEF.
    issue(16'h0040, 16'h0, 1'b1, 1'b0, 3'd3, 1'b1);
    @(negedge clk);
    chk("ld_acc_wb_valid", 32'(wb_valid), 32'd0);
    idle_inputs();
    low_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ld_req_c%0d", k), 32'(dm_req), 32'd1);
      chk($sformatf("ld_addr_c%0d", k), 32'(dm_addr), 32'h0040);
      chk($sformatf("ld_we_c%0d", k), 32'(dm_we), 32'd0);
      if (!ex_ready) low_cnt++;
      if (k == 2) begin
        dm_ack   = 1'b1;
        dm_rdata = 16'hBEEF;
      end
      @(negedge clk);
    end
    dm_ack = 1'b0;
    chk("ld_ready_low_cycles", 32'(low_cnt), 32'd3);
    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld_wb_data", 32'(wb_data), 32'hBEEF);
    chk("ld_wb_rd", 32'(wb_rd), 32'd3);
    chk("ld_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("ld_dm_req_drop", 32'(dm_req), 32'd0);
    chk("ld_ex_ready", 32'(ex_ready), 32'd1);

    // Store 0x00FF to 0x0010 with immediate ack, then accept on the retire cycle.
    issue(16'h0010, 16'h00FF, 1'b0, 1'b1, 3'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("st_dm_req", 32'(dm_req), 32'd1);
    chk("st_dm_we", 32'(dm_we), 32'd1);
    chk("st_dm_wdata", 32'(dm_wdata), 32'h00FF);
    chk("st_dm_addr", 32'(dm_addr), 32'h0010);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("st_wb_valid", 32'(wb_valid), 32'd1);
    chk("st_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("st_wb_data", 32'(wb_data), 32'h0010);
    chk("st_ex_ready", 32'(ex_ready), 32'd1);
    issue(16'h5555, 16'h0, 1'b0, 1'b0, 3'd1, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("st_next_wb_valid", 32'(wb_valid), 32'd1);
    chk("st_next_wb_data", 32'(wb_data), 32'h5555);
    chk("st_next_wb_rd", 32'(wb_rd), 32'd1);

    // mem_read and mem_write both set: behaves as a store.
    issue(16'h0020, 16'hAAAA, 1'b1, 1'b1, 3'd4, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("rw_dm_we", 32'(dm_we), 32'd1);
    chk("rw_dm_addr", 32'(dm_addr), 32'h0020);
    dm_ack   = 1'b1;
    dm_rdata = 16'h9999;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("rw_wb_valid", 32'(wb_valid), 32'd1);
    chk("rw_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("rw_wb_data", 32'(wb_data), 32'h0020);

    // Ack on the last allowed cycle beats the timeout.
    issue(16'h0044, 16'h0, 1'b1, 1'b0, 3'd6, 1'b1);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("edge_req_c4", 32'(dm_req), 32'd1);
    dm_ack   = 1'b1;
    dm_rdata = 16'h1357;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("edge_wb_valid", 32'(wb_valid), 32'd1);
    chk("edge_wb_data", 32'(wb_data), 32'h1357);
    chk("edge_mem_err", 32'(mem_err), 32'd0);

    // No ack: timeout after MAX_WAIT=4 ACCESS cycles.
    issue(16'h0030, 16'h0, 1'b1, 1'b0, 3'd5, 1'b1);
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_req_c%0d", k), 32'(dm_req), 32'd1);
      chk($sformatf("to_err_c%0d", k), 32'(mem_err), 32'd0);
      @(negedge clk);
    end
    chk("to_dm_req_drop", 32'(dm_req), 32'd0);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_wb_data", 32'(wb_data), 32'd0);
    chk("to_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("to_ex_ready", 32'(ex_ready), 32'd1);
    issue(16'h0F0F, 16'h0, 1'b0, 1'b0, 3'd1, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("to_sticky_wb_data", 32'(wb_data), 32'h0F0F);
    chk("to_sticky_err", 32'(mem_err), 32'd1);
    @(negedge clk);
    chk("to_sticky_err2", 32'(mem_err), 32'd1);

    // Reset during ACCESS: immediate abort, late ack ignored.
    issue(16'h0050, 16'h0, 1'b1, 1'b0, 3'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("rstm_req_before", 32'(dm_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_dm_req", 32'(dm_req), 32'd0);
    chk("rstm_ex_ready", 32'(ex_ready), 32'd1);
    chk("rstm_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstm_mem_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dm_ack   = 1'b1;
    dm_rdata = 16'h7777;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_dm_req", 32'(dm_req), 32'd0);
    chk("late_ack_wb_data", 32'(wb_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
